tcu_drl_align_pipe: RTL and testbench
=====================================

Name: tcu_drl_align_pipe

Overview:
- Pipelined, back-pressurable alignment stage for the TCU FEDP datapath.
- Accepts per-lane biased exponents and signed-magnitude significands, computes the max exponent and per-lane shift amounts internally, then aligns, computes sticky bits, and converts to two's complement.
- Sits between the FEDP multiplier stage and the carry-save accumulator. Generalises the fixed combinational aligner with parametric pre-shift, exponent width, lane masking and valid/ready flow control.

Parameters:
- N, 5, lane count; lane N-1 is the C (accumulator) term when C_LANE=1.
- WI, 25, input significand width: sign + (WI-1) magnitude bits.
- WO, WI+2, output two's-complement width.
- EW, 8, biased exponent width.
- PRE_SHIFT, WI-23, left pre-shift for product lanes; the C lane uses PRE_SHIFT-1.
- C_LANE, 1, 1 = lane N-1 uses the C-term pre-shift.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, request valid.
- ready_in, output, 1, block can accept a request.
- req_id, input, 32, tag carried through the pipeline.
- is_int, input, 1, integer mode: sign-extend, no alignment.
- lane_en, input, N, lane participates; disabled lanes output zero.
- exps_in, input, N*EW, biased exponents.
- sigs_in, input, N*WI, significands.
- valid_out, output, 1, result valid.
- ready_out, input, 1, downstream accepts.
- req_id_out, output, 32, tag.
- max_exp, output, EW, maximum exponent of enabled lanes.
- sigs_out, output, N*WO, aligned two's-complement significands.
- sticky_bits, output, N, OR of bits shifted out per lane.

Behaviour:
- Three register stages, A, B and C. Latency is 3 cycles with ready_out held high; throughput is 1 per cycle.
- Stage A:
  - max_exp = max of exps_in over enabled lanes; 0 if no lane is enabled.
  - shift[i] = max_exp - exps_in[i], saturated to 8 bits (255).
- Stage B:
  - mag_shifted = magnitude << PRE_SHIFT (C lane: << PRE_SHIFT-1), in SW = WI-1+PRE_SHIFT bits.
  - Right-shift by shift[i]; keep the low WO-1 bits.
  - Overshift (shift >= SW): magnitude = 0, sticky = |mag_shifted.
  - Otherwise sticky = OR of the low shift[i] bits of mag_shifted. shift = 0 gives sticky 0.
- Stage C: negate when sign = 1, giving WO bits, and register the outputs.
- is_int: sigs_out[i] = sign-extended sigs_in[i]; sticky = 0; exps are ignored; max_exp output = 0.
- Disabled lane: sigs_out = 0 and sticky = 0, in both modes.
- Negative zero (sign 1, magnitude 0) outputs 0.
- Handshake:
  - A stage loads when its register is empty or its content advances in the same cycle.
  - ready_in = stage A can load. ready_in may depend combinationally on ready_out.
  - Transfer in occurs on valid_in & ready_in; transfer out on valid_out & ready_out.
  - While valid_out & !ready_out, all outputs hold stable.
  - No drop, no duplication, in-order delivery.
  - With 3 entries held, ready_in = 0. When ready_out rises, ready_in rises in the same cycle.
- Reset:
  - All stage valids and all output registers clear to 0 asynchronously. This covers valid_out, req_id_out, max_exp, sigs_out and sticky_bits.
  - In-flight requests are discarded.
  - ready_in = 1 in the first cycle after reset_n deasserts.

Optional Feature:
- TCU_ALIGN_STICKY_EN
- Defined: sticky_bits are computed as above.
- Undefined: sticky_bits are tied to 0 and no sticky logic is synthesised. This suits truncation-only configurations. Datapath results and latency are unchanged.

Decomposition:
- Package VX_tcu_pkg gets:
  - constant TCU_ALIGN_SHW = 8;
  - function tcu_align_sw(WI, PRE_SHIFT);
  - a per-lane stage struct typedef.
- One sub-module, tcu_drl_align_lane: a single lane's shift, sticky and negate logic. It is combinational and instantiated N times between registers.

Test Plan:
- Aligned values. Config N=5, WI=25, all exps 127, all lanes on, sign 0, magnitude 0x800000. Expect lanes 0-3 = 0x2000000, lane 4 = 0x1000000, sticky 0, max_exp 127, output 3 cycles after input.
- Overshift. Lane 1 exp 100, others 127, lane 1 magnitude nonzero. Expect shift 27 >= 26, lane 1 output 0, sticky[1] = 1.
- Negative value. Lane 0 sign 1, magnitude 0x000001, max exp. Expect sigs_out[0] = 0x7FFFFFC (-4), sticky 0.
- Partial shift with sticky. Lane 2 magnitude 0x000003 with shift 3. Expect output 0x1, sticky 1. Lane_en = 0 on lane 3 with exp 200: max_exp excludes it and lane 3 output is 0.
- Integer mode and back-pressure:
  - is_int = 1 with sigs_in 0x1FFFFFF: expect sigs_out 0x7FFFFFF, sticky 0.
  - Stream 6 requests with ready_out low for cycles 2-6: expect ready_in = 0 once 3 entries are held, then all 6 delivered in order with correct req_id_out and outputs stable while stalled.
- Reset mid-flight. Drop reset_n with 2 requests in flight. Expect valid_out = 0 and all outputs = 0 immediately, ready_in = 1 after release, and no stale data emitted afterwards.

Source files
------------

// File: rtl/tcu_drl_align_pipe_pkg.sv
// VX_tcu_pkg: shared shift-width constant, per-lane stage record and width helper for the TCU aligner.
package VX_tcu_pkg;
    localparam int TCU_ALIGN_SHW = 8;
    typedef struct packed {
        logic                     en;
        logic                     sign;
        logic [TCU_ALIGN_SHW-1:0] shift;
    } tcu_align_lane_t;
    function automatic int tcu_align_sw(input int wi, input int pre_shift);
        return wi - 1 + pre_shift;
    endfunction
endpackage

// File: rtl/tcu_drl_align_pipe_if.sv
// tcu_drl_align_pipe_if: request/response bus of the alignment pipe; master = producer/consumer, slave = pipe.
interface tcu_drl_align_pipe_if #(
    parameter int N  = 5,
    parameter int WI = 25,
    parameter int WO = WI + 2,
    parameter int EW = 8
);
    logic            valid_in;
    logic            ready_in;
    logic [31:0]     req_id;
    logic            is_int;
    logic [N-1:0]    lane_en;
    logic [N*EW-1:0] exps_in;
    logic [N*WI-1:0] sigs_in;
    logic            valid_out;
    logic            ready_out;
    logic [31:0]     req_id_out;
    logic [EW-1:0]   max_exp;
    logic [N*WO-1:0] sigs_out;
    logic [N-1:0]    sticky_bits;
    modport master (
        output valid_in, req_id, is_int, lane_en, exps_in, sigs_in, ready_out,
        input  ready_in, valid_out, req_id_out, max_exp, sigs_out, sticky_bits
    );
    modport slave (
        input  valid_in, req_id, is_int, lane_en, exps_in, sigs_in, ready_out,
        output ready_in, valid_out, req_id_out, max_exp, sigs_out, sticky_bits
    );
endinterface

// File: rtl/tcu_drl_align_pipe_lane.sv
// tcu_drl_align_lane: one lane's align + sticky path (A->B) and sign fix-up path (B->C).
// Sticky logic exists only when TCU_ALIGN_STICKY_EN is defined.
module tcu_drl_align_lane import VX_tcu_pkg::*; #(
    parameter int WI  = 25,
    parameter int WO  = WI + 2,
    parameter int PRE = 2,
    parameter int SW  = 26
) (
    input  logic            is_int_i,
    input  tcu_align_lane_t lane_i,
    input  logic [WI-2:0]   mag_i,
    output logic [WO-1:0]   val_o,
    output logic            neg_o,
    output logic            sticky_o,
    input  logic [WO-1:0]   val_i,
    input  logic            neg_i,
    output logic [WO-1:0]   sig_o
);
    localparam int MW = SW > WO - 1 ? SW : WO - 1;
    logic [SW-1:0] mag_sh;
    logic [MW-1:0] aligned;
    assign mag_sh  = SW'(mag_i) << PRE;
    assign aligned = MW'(mag_sh >> lane_i.shift);
    // Integer lanes are already two's complement, so they bypass the negate stage.
    assign val_o = !lane_i.en ? '0
                 : is_int_i   ? {{(WO-WI){lane_i.sign}}, lane_i.sign, mag_i}
                 :              {1'b0, aligned[WO-2:0]};
    assign neg_o = lane_i.en & !is_int_i & lane_i.sign;
`ifdef TCU_ALIGN_STICKY_EN
    // Mask of the bits shifted out; an overshift makes it all ones.
    assign sticky_o = lane_i.en & !is_int_i & |(mag_sh & ~({SW{1'b1}} << lane_i.shift));
`else
    assign sticky_o = 1'b0;
`endif
    assign sig_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/tcu_drl_align_pipe.sv
// tcu_drl_align_pipe: 3-stage valid/ready FEDP aligner (A: max exp/shift, B: align/sticky, C: two's complement).
// Optional sticky generation: TCU_ALIGN_STICKY_EN.
module tcu_drl_align_pipe import VX_tcu_pkg::*; #(
    parameter int N         = 5,
    parameter int WI        = 25,
    parameter int WO        = WI + 2,
    parameter int EW        = 8,
    parameter int PRE_SHIFT = WI - 23,
    parameter int C_LANE    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tcu_drl_align_pipe_if.slave  bus
);
    localparam int SW = tcu_align_sw(WI, PRE_SHIFT);
    logic                       va_q, vb_q, vc_q, ld_a, ld_b, ld_c;
    logic [31:0]                id_a_q, id_b_q, id_c_q;
    logic [EW-1:0]              max_d, max_a_q, max_b_q, max_c_q, diff;
    logic                       int_a_q;
    tcu_align_lane_t [N-1:0]    lane_d, lane_a_q;
    logic [N-1:0][WI-2:0]       mag_d, mag_a_q;
    logic [N-1:0][WO-1:0]       val_d, val_b_q, sig_d, sig_c_q;
    logic [N-1:0]               neg_d, neg_b_q, sticky_d, sticky_b_q, sticky_c_q;
    // Each stage loads when empty or when its content moves on this cycle.
    assign ld_c         = !vc_q | bus.ready_out;
    assign ld_b         = !vb_q | ld_c;
    assign ld_a         = !va_q | ld_b;
    assign bus.ready_in = ld_a;
    always_comb begin
        max_d  = '0;
        diff   = '0;
        lane_d = '0;
        mag_d  = '0;
        for (int i = 0; i < N; i++)
            if (bus.lane_en[i] && !bus.is_int && bus.exps_in[i*EW +: EW] > max_d) max_d = bus.exps_in[i*EW +: EW];
        for (int i = 0; i < N; i++) begin
            diff            = max_d - bus.exps_in[i*EW +: EW];
            lane_d[i].en    = bus.lane_en[i];
            lane_d[i].sign  = bus.sigs_in[i*WI + WI-1];
            lane_d[i].shift = (EW > TCU_ALIGN_SHW && (diff >> TCU_ALIGN_SHW) != '0) ? '1 : TCU_ALIGN_SHW'(diff);
            mag_d[i]        = bus.sigs_in[i*WI +: WI-1];
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_lane
        tcu_drl_align_lane #(
            .WI(WI), .WO(WO), .SW(SW),
            .PRE((C_LANE != 0 && i == N-1) ? PRE_SHIFT - 1 : PRE_SHIFT)
        ) u_lane (
            .is_int_i(int_a_q), .lane_i(lane_a_q[i]), .mag_i(mag_a_q[i]),
            .val_o(val_d[i]), .neg_o(neg_d[i]), .sticky_o(sticky_d[i]),
            .val_i(val_b_q[i]), .neg_i(neg_b_q[i]), .sig_o(sig_d[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            va_q       <= 1'b0;
            vb_q       <= 1'b0;
            vc_q       <= 1'b0;
            id_a_q     <= '0;
            id_b_q     <= '0;
            id_c_q     <= '0;
            max_a_q    <= '0;
            max_b_q    <= '0;
            max_c_q    <= '0;
            int_a_q    <= 1'b0;
            lane_a_q   <= '0;
            mag_a_q    <= '0;
            val_b_q    <= '0;
            neg_b_q    <= '0;
            sticky_b_q <= '0;
            sig_c_q    <= '0;
            sticky_c_q <= '0;
        end else begin
            if (ld_a) va_q <= bus.valid_in;
            if (ld_a && bus.valid_in) begin
                id_a_q   <= bus.req_id;
                max_a_q  <= max_d;
                int_a_q  <= bus.is_int;
                lane_a_q <= lane_d;
                mag_a_q  <= mag_d;
            end
            if (ld_b) vb_q <= va_q;
            if (ld_b && va_q) begin
                id_b_q     <= id_a_q;
                max_b_q    <= max_a_q;
                val_b_q    <= val_d;
                neg_b_q    <= neg_d;
                sticky_b_q <= sticky_d;
            end
            if (ld_c) vc_q <= vb_q;
            if (ld_c && vb_q) begin
                id_c_q     <= id_b_q;
                max_c_q    <= max_b_q;
                sig_c_q    <= sig_d;
                sticky_c_q <= sticky_b_q;
            end
        end
    end
    assign bus.valid_out   = vc_q;
    assign bus.req_id_out  = id_c_q;
    assign bus.max_exp     = max_c_q;
    assign bus.sigs_out    = sig_c_q;
    assign bus.sticky_bits = sticky_c_q;
endmodule

// File: tb/tb_tcu_drl_align_pipe.sv
// tb_tcu_drl_align_pipe: table-driven vectors checked through an in-order scoreboard,
// plus latency, back-pressure and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_tcu_drl_align_pipe;
    localparam int N = 5, WI = 25, WO = 27, EW = 8, NV = 9;
    localparam logic [WI-1:0] M = 25'h0800000;
`ifdef TCU_ALIGN_STICKY_EN
    localparam logic [N-1:0] STK = '1;
`else
    localparam logic [N-1:0] STK = '0;
`endif
    typedef struct {
        logic                 is_int;
        logic [N-1:0]         en;
        logic [N-1:0][EW-1:0] exps;
        logic [N-1:0][WI-1:0] sigs;
        logic [N-1:0][WO-1:0] outs;
        logic [N-1:0]         stk;
        logic [EW-1:0]        mx;
    } vec_t;
    typedef struct {
        logic [31:0] id;
        int          vi;
    } sb_t;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          total = 0, passed = 0, cur_vi = 0, lat = 0;
    logic [31:0] cur_id = '0;
    logic        stalled = 1'b0, seen = 1'b0;
    logic [180:0] snap = '0, obs;
    vec_t        vec [NV];
    sb_t         sb [$];
    sb_t         e;

    tcu_drl_align_pipe_if #(.N(N), .WI(WI), .WO(WO), .EW(EW)) bus ();
    tcu_drl_align_pipe #(.N(N), .WI(WI), .WO(WO), .EW(EW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    assign obs = {bus.valid_out, bus.req_id_out, bus.max_exp, bus.sigs_out, bus.sticky_bits};

    task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset_n) stalled = 1'b0;
        else begin
            if (stalled) check("stall_hold", 192'(obs), 192'(snap));
            if (bus.valid_out && bus.ready_out) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL spurious_out: got id %0h, expected no output", bus.req_id_out);
                end else begin
                    e = sb.pop_front();
                    check("req_id_out", 192'(bus.req_id_out), 192'(e.id));
                    check("max_exp", 192'(bus.max_exp), 192'(vec[e.vi].mx));
                    check("sigs_out", 192'(bus.sigs_out), 192'(vec[e.vi].outs));
                    check("sticky_bits", 192'(bus.sticky_bits), 192'(vec[e.vi].stk));
                end
            end
            if (bus.valid_in && bus.ready_in) sb.push_back('{cur_id, cur_vi});
            stalled = bus.valid_out && !bus.ready_out;
            snap    = obs;
        end
    end

    task automatic drive(input int vi, input logic [31:0] id);
        cur_vi        = vi;
        cur_id        = id;
        bus.valid_in  = 1'b1;
        bus.req_id    = id;
        bus.is_int    = vec[vi].is_int;
        bus.lane_en   = vec[vi].en;
        bus.exps_in   = vec[vi].exps;
        bus.sigs_in   = vec[vi].sigs;
    endtask

    task automatic send(input int vi, input logic [31:0] id, input bit rnd);
        bit acc = 1'b0;
        int n = 0;
        drive(vi, id);
        do begin
            if (rnd) bus.ready_out = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.ready_in;
            n++;
            @(posedge clk);
            #1;
        end while (!acc && n < 64);
        bus.valid_in = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL send_timeout: id %0h not accepted after %0d cycles, expected acceptance", id, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        bus.ready_out = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 192'(sb.size()), 192'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in = 1'b0; bus.ready_out = 1'b1; bus.req_id = '0; bus.is_int = 1'b0;
        bus.lane_en = '0; bus.exps_in = '0; bus.sigs_in = '0;
        vec[0] = '{1'b0, 5'h1F, {5{8'd127}}, {5{M}},
                   {27'h1000000, {4{27'h2000000}}}, 5'h00, 8'd127};
        vec[1] = '{1'b0, 5'h1F, {8'd127, 8'd127, 8'd127, 8'd100, 8'd127}, {5{M}},
                   {27'h1000000, 27'h2000000, 27'h2000000, 27'h0, 27'h2000000}, STK & 5'b00010, 8'd127};
        vec[2] = '{1'b0, 5'h1F, {5{8'd127}}, {M, M, M, M, 25'h1000001},
                   {27'h1000000, 27'h2000000, 27'h2000000, 27'h2000000, 27'h7FFFFFC}, 5'h00, 8'd127};
        vec[3] = '{1'b0, 5'b10111, {8'd127, 8'd200, 8'd124, 8'd127, 8'd127}, {M, M, 25'h0000003, M, M},
                   {27'h1000000, 27'h0, 27'h1, 27'h2000000, 27'h2000000}, STK & 5'b00100, 8'd127};
        vec[4] = '{1'b1, 5'h1F, {8'd50, 8'd1, 8'd255, 8'd0, 8'd90}, {5{25'h1FFFFFF}},
                   {5{27'h7FFFFFF}}, 5'h00, 8'd0};
        vec[5] = '{1'b1, 5'b11011, {5{8'd200}}, {25'h1FFFFFE, 25'h0FFFFFF, 25'h1FFFFFF, 25'h1000000, 25'h0000005},
                   {27'h7FFFFFE, 27'h0FFFFFF, 27'h0, 27'h7000000, 27'h0000005}, 5'h00, 8'd0};
        vec[6] = '{1'b0, 5'b10011, {5{8'd127}}, {25'h1800000, M, M, 25'h1800000, 25'h1000000},
                   {27'h7000000, 27'h0, 27'h0, 27'h6000000, 27'h0}, 5'h00, 8'd127};
        vec[7] = '{1'b0, 5'h00, {5{8'd200}}, {5{M}}, '0, 5'h00, 8'd0};
        vec[8] = '{1'b0, 5'h1F, {8'd130, 8'd104, 8'd105, 8'd130, 8'd129}, {M, M, 25'h0FFFFFF, 25'h0000001, M},
                   {27'h1000000, 27'h0, 27'h1, 27'h4, 27'h1000000}, STK & 5'b01100, 8'd130};
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_valid_out", 192'(bus.valid_out), 192'(0));
        check("rst_ready_in", 192'(bus.ready_in), 192'(1));
        check("rst_outputs", 192'({bus.req_id_out, bus.max_exp, bus.sigs_out, bus.sticky_bits}), 192'(0));
        @(posedge clk);
        #1;
        send(0, 32'hA0, 1'b0);
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (bus.valid_out) break;
            @(posedge clk);
            lat++;
        end
        check("latency", 192'(lat), 192'(3));
        drain();
        for (int i = 0; i < NV; i++) send(i, 32'h100 + i, 1'b0);
        drain();
        bus.ready_out = 1'b0;
        send(0, 32'h200, 1'b0);
        send(1, 32'h201, 1'b0);
        send(2, 32'h202, 1'b0);
        drive(3, 32'h203);
        @(negedge clk);
        check("ready_in_full", 192'(bus.ready_in), 192'(0));
        check("bp_head_id", 192'(bus.req_id_out), 192'(32'h200));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.ready_out = 1'b1;
        #1;
        check("ready_in_rise", 192'(bus.ready_in), 192'(1));
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        send(4, 32'h204, 1'b0);
        send(5, 32'h205, 1'b0);
        drain();
        send(2, 32'h300, 1'b0);
        send(3, 32'h301, 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_valid", 192'(bus.valid_out), 192'(1));
        reset_n = 1'b0;
        #1;
        check("reset_valid_out", 192'(bus.valid_out), 192'(0));
        check("reset_outputs", 192'({bus.req_id_out, bus.max_exp, bus.sigs_out, bus.sticky_bits}), 192'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_in_after_reset", 192'(bus.ready_in), 192'(1));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.valid_out;
        end
        check("no_stale", 192'(seen), 192'(0));
        @(posedge clk);
        #1;
        send(8, 32'h400, 1'b0);
        drain();
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(int'($urandom_range(0, NV - 1)), 32'h500 + i, 1'b1);
        end
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
